key_req_pulse: RTL and testbench

- Upstream stage for the FIFO request path. Converts one raw active-low pushbutton into clean single-cycle request pulses that drive the FIFO's wrreq or rdreq.
- Synchronises and debounces the button, emits exactly one pulse per press, and optionally auto-repeats while the button is held.
- Suppresses the request when the consumer signals blocked (FIFO full or empty), and counts dropped requests.
- One instance per button; all logic runs in the clock_50mhz domain, and the consuming FIFO is clocked from the same clock.

---
 rtl/key_req_pkg.sv | 16 +
 rtl/bit_sync2.sv | 25 ++
 rtl/key_req_pulse.sv | 128 ++++++++++++
 tb/tb_key_req_pulse.sv | 187 ++++++++++++++++++
 4 files changed

// File: rtl/key_req_pkg.sv
// Shared types and constants for the pushbutton request-pulse path.
// Imported by key_req_pulse and anything that decodes its debounce state.
package key_req_pkg;

    typedef enum logic [2:0] {
        RELEASED,
        PRESS_WAIT,
        HELD,
        REPEAT,
        RELEASE_WAIT
    } state_t;

    localparam int DROP_CNT_W = 8;
    localparam logic [DROP_CNT_W-1:0] DROP_CNT_MAX = DROP_CNT_W'(255);

endpackage

// File: rtl/bit_sync2.sv
// Two-flop synchroniser for a single asynchronous input bit.
// RESET_VALUE sets the idle level the flops hold while in reset.
module bit_sync2 #(
    parameter logic RESET_VALUE = 1'b1
) (
    input  logic clock_50mhz,
    input  logic reset,
    input  logic d,
    output logic q
);

    logic meta;

    // NOTE: sequential state uses non-blocking (<=) so meta and q update together and form a real 2-stage shift.
    always_ff @(posedge clock_50mhz or posedge reset) begin
        if (reset) begin
            meta <= RESET_VALUE;
            q    <= RESET_VALUE;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/key_req_pulse.sv
// Debounces one active-low pushbutton into single-cycle FIFO request pulses,
// with optional auto-repeat, request suppression while blocked and a drop counter.
module key_req_pulse
    import key_req_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYCLES = 1000000,
    parameter int unsigned HOLD_CYCLES     = 25000000,
    parameter int unsigned REPEAT_CYCLES   = 5000000,
    parameter int unsigned REPEAT_EN       = 1,
    parameter int unsigned CNT_W           = 25
) (
    input  logic                  clock_50mhz,
    input  logic                  reset,
    input  logic                  key_n,
    input  logic                  block,
    output logic                  req_pulse,
    output logic                  drop_pulse,
    output logic                  key_level,
    output logic [DROP_CNT_W-1:0] drop_count
);

    localparam logic [CNT_W-1:0] DEB_LAST  = CNT_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(HOLD_CYCLES - 1);
    localparam logic [CNT_W-1:0] REP_LAST  = CNT_W'(REPEAT_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);

    logic             key_s;
    state_t           state, state_next;
    logic [CNT_W-1:0] timer, timer_next;
    logic             level_next;
    logic             fire;

    bit_sync2 #(.RESET_VALUE(1'b1)) u_key_sync (
        .clock_50mhz (clock_50mhz),
        .reset       (reset),
        .d           (key_n),
        .q           (key_s)
    );

    // NOTE: every always_comb output is given a default first so no path can leave it unassigned (no latch).
    always_comb begin
        state_next = state;
        timer_next = timer;
        level_next = key_level;
        fire       = 1'b0;
        case (state)
            RELEASED: begin
                if (!key_s) begin
                    state_next = PRESS_WAIT;
                    timer_next = '0;
                end
            end
            PRESS_WAIT: begin
                if (key_s) begin
                    state_next = RELEASED;
                end else if (timer == DEB_LAST) begin
                    state_next = HELD;
                    timer_next = '0;
                    level_next = 1'b1;
                    fire       = 1'b1;
                end else begin
                    timer_next = timer + CNT_ONE;
                end
            end
            HELD: begin
                if (key_s) begin
                    state_next = RELEASE_WAIT;
                    timer_next = '0;
                end else if (REPEAT_EN != 0 && timer == HOLD_LAST) begin
                    state_next = REPEAT;
                    timer_next = '0;
                    fire       = 1'b1;
                end else if (timer != HOLD_LAST) begin
                    // Parks at HOLD_LAST when repeat is off rather than wrapping.
                    timer_next = timer + CNT_ONE;
                end
            end
            REPEAT: begin
                if (key_s) begin
                    state_next = RELEASE_WAIT;
                    timer_next = '0;
                end else if (timer == REP_LAST) begin
                    timer_next = '0;
                    fire       = 1'b1;
                end else begin
                    timer_next = timer + CNT_ONE;
                end
            end
            RELEASE_WAIT: begin
                if (!key_s) begin
                    state_next = HELD;
                    timer_next = '0;
                end else if (timer == DEB_LAST) begin
                    state_next = RELEASED;
                    timer_next = '0;
                    level_next = 1'b0;
                end else begin
                    timer_next = timer + CNT_ONE;
                end
            end
            default: begin
                state_next = RELEASED;
                timer_next = '0;
            end
        endcase
    end

    always_ff @(posedge clock_50mhz or posedge reset) begin
        if (reset) begin
            state      <= RELEASED;
            timer      <= '0;
            key_level  <= 1'b0;
            req_pulse  <= 1'b0;
            drop_pulse <= 1'b0;
            drop_count <= '0;
        end else begin
            state      <= state_next;
            timer      <= timer_next;
            key_level  <= level_next;
            req_pulse  <= fire & ~block;
            drop_pulse <= fire & block;
            if (fire && block && drop_count != DROP_CNT_MAX) begin
                drop_count <= drop_count + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_key_req_pulse.sv
// Randomised and directed stimulus for key_req_pulse, checked every cycle against
// a run-length model of the debounce/hold/repeat rules (repeat on and off instances).
module tb_key_req_pulse;

    localparam int DEB  = 4;
    localparam int HOLD = 10;
    localparam int REP  = 3;

    logic       clock_50mhz;
    logic       reset;
    logic       key_n;
    logic       block;
    logic       req_a, drop_a, level_a;
    logic       req_b, drop_b, level_b;
    logic [7:0] count_a, count_b;

    int n_cmp = 0;
    int n_bad = 0;

    key_req_pulse #(
        .DEBOUNCE_CYCLES (DEB), .HOLD_CYCLES (HOLD), .REPEAT_CYCLES (REP),
        .REPEAT_EN (1), .CNT_W (4)
    ) dut_rep (
        .clock_50mhz (clock_50mhz), .reset (reset), .key_n (key_n), .block (block),
        .req_pulse (req_a), .drop_pulse (drop_a), .key_level (level_a), .drop_count (count_a)
    );

    key_req_pulse #(
        .DEBOUNCE_CYCLES (DEB), .HOLD_CYCLES (HOLD), .REPEAT_CYCLES (REP),
        .REPEAT_EN (0), .CNT_W (4)
    ) dut_one (
        .clock_50mhz (clock_50mhz), .reset (reset), .key_n (key_n), .block (block),
        .req_pulse (req_b), .drop_pulse (drop_b), .key_level (level_b), .drop_count (count_b)
    );

    initial begin
        clock_50mhz = 1'b0;
        forever #5 clock_50mhz = ~clock_50mhz;
    end

    // Reference model: key history, run lengths of the synchronised key, per-instance results.
    logic [1:0] hist;
    int         low_run, high_run;
    logic       m_level [2];
    int         m_age   [2];
    logic       m_req   [2];
    logic       m_drop  [2];
    int         m_cnt   [2];

    task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s @%0t: got %0d expected %0d", tag, $time, got, exp);
        end
    endtask

    task automatic model_reset();
        hist     = 2'b11;
        low_run  = 0;
        high_run = 0;
        for (int i = 0; i < 2; i++) begin
            m_level[i] = 1'b0;
            m_age[i]   = 0;
            m_req[i]   = 1'b0;
            m_drop[i]  = 1'b0;
            m_cnt[i]   = 0;
        end
    endtask

    task automatic model_step();
        logic ks;
        logic fire;
        ks      = hist[1];
        hist[1] = hist[0];
        hist[0] = key_n;
        if (!ks) begin
            low_run++;
            high_run = 0;
        end else begin
            high_run++;
            low_run = 0;
        end
        for (int i = 0; i < 2; i++) begin
            fire = 1'b0;
            if (!m_level[i]) begin
                if (!ks && low_run == DEB + 1) begin
                    m_level[i] = 1'b1;
                    m_age[i]   = 0;
                    fire       = 1'b1;
                end
            end else if (ks) begin
                if (high_run == DEB + 1) m_level[i] = 1'b0;
            end else begin
                m_age[i] = (low_run == 1) ? 0 : m_age[i] + 1;
                if (i == 0 && m_age[i] >= HOLD && (m_age[i] - HOLD) % REP == 0) fire = 1'b1;
            end
            m_req[i]  = fire && !block;
            m_drop[i] = fire && block;
            if (fire && block && m_cnt[i] < 255) m_cnt[i]++;
        end
    endtask

    task automatic compare_all();
        check("req_rep",    {7'd0, req_a},   {7'd0, m_req[0]});
        check("drop_rep",   {7'd0, drop_a},  {7'd0, m_drop[0]});
        check("level_rep",  {7'd0, level_a}, {7'd0, m_level[0]});
        check("req_one",    {7'd0, req_b},   {7'd0, m_req[1]});
        check("drop_one",   {7'd0, drop_b},  {7'd0, m_drop[1]});
        check("level_one",  {7'd0, level_b}, {7'd0, m_level[1]});
        check("excl_rep",   {7'd0, req_a & drop_a}, 8'd0);
        // drop_count is compared only outside the drop_pulse cycle itself.
        if (!m_drop[0]) check("count_rep", count_a, 8'(m_cnt[0]));
        if (!m_drop[1]) check("count_one", count_b, 8'(m_cnt[1]));
    endtask

    task automatic cycle(input logic kn, input logic blk);
        key_n = kn;
        block = blk;
        @(posedge clock_50mhz);
        if (reset) model_reset();
        else model_step();
        @(negedge clock_50mhz);
        compare_all();
    endtask

    task automatic run(input logic kn, input int n, input logic blk);
        for (int i = 0; i < n; i++) cycle(kn, blk);
    endtask

    initial begin
        reset = 1'b1;
        key_n = 1'b1;
        block = 1'b0;
        model_reset();
        @(negedge clock_50mhz);
        compare_all();
        cycle(1'b1, 1'b0);
        reset = 1'b0;
        run(1'b1, 4, 1'b0);

        // Clean press, bounce, auto-repeat hold.
        run(1'b0, 8, 1'b0);  run(1'b1, 12, 1'b0);
        run(1'b0, 2, 1'b0);  run(1'b1, 1, 1'b0);
        run(1'b0, 2, 1'b0);  run(1'b1, 1, 1'b0);
        run(1'b0, 10, 1'b0); run(1'b1, 12, 1'b0);
        run(1'b0, 30, 1'b0); run(1'b1, 12, 1'b0);

        // Blocked clean press.
        run(1'b0, 8, 1'b1);  run(1'b1, 12, 1'b1);
        check("drop_single", count_a, 8'd1);

        // Release glitch while held.
        run(1'b0, 20, 1'b0); run(1'b1, 2, 1'b0);
        run(1'b0, 25, 1'b0); run(1'b1, 12, 1'b0);

        // Async reset while repeating, key still held afterwards.
        run(1'b0, 20, 1'b0);
        #2 reset = 1'b1;
        model_reset();
        #1 compare_all();
        run(1'b0, 2, 1'b0);
        reset = 1'b0;
        run(1'b0, 14, 1'b0);
        run(1'b1, 12, 1'b0);

        // Random bouncing key with random blocking.
        for (int s = 0; s < 300; s++) begin
            automatic logic kn = s[0];
            automatic int   len = $urandom_range(1, 20);
            for (int c = 0; c < len; c++) cycle(kn, ($urandom_range(0, 3) == 0));
        end
        run(1'b1, 12, 1'b0);

        // Saturation of the drop counter.
        for (int p = 0; p < 300; p++) begin
            run(1'b0, 7, 1'b1);
            run(1'b1, 8, 1'b1);
        end
        check("drop_sat_rep", count_a, 8'd255);
        check("drop_sat_one", count_b, 8'd255);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
